hes_ctr_stream_pipe: RTL and testbench
======================================

Name: hes_ctr_stream_pipe

Overview:
- Multi-lane, pipelined successor of the HES byte stream cipher.
- Encrypts or decrypts LANES bytes per beat: each data byte is XORed with SBOX(key + byte_index) mod 256.
- Adds a valid/ready handshake with backpressure, message framing (sop/last), partial-beat masks and a 2-stage pipeline.
- Sits between the byte-stream ingress framer and the egress packer. Encrypt and decrypt are the same operation.

Parameters:
- LANES, 4, bytes processed per beat (1..16); lane j = data bits [8j+7:8j].
- CTR_STEP_KEEP, 0, 0: byte index advances by LANES per beat; 1: advances by popcount(in_keep).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- key  in  8  message key, sampled only on an accepted beat with in_sop=1
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_sop  in  1  first beat of a message
- in_last  in  1  final beat of a message
- in_keep  in  LANES  per-lane byte-valid mask
- in_data  in  8*LANES  plaintext or ciphertext
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output
- out_sop / out_last  out  1  framing, delayed alongside the data
- out_keep  out  LANES  echoed mask
- out_data  out  8*LANES  result; masked lanes forced to 0x00
- err_no_sop  out  1  one-cycle pulse when a beat is dropped in IDLE

Behaviour:
- Accept rule: a beat is accepted when in_valid & in_ready.
- Output transfer: a beat leaves when out_valid & out_ready.
- Framing FSM, states IDLE and ACTIVE:
  - IDLE + accepted sop: key_q<=key, idx<=0, go to ACTIVE.
  - ACTIVE + accepted last: go to IDLE after the beat is processed.
  - sop and last on the same beat: single-beat message; stays/returns IDLE.
  - sop while ACTIVE: restart. key_q and idx reload; the previous message is truncated with no error.
  - Accepted non-sop beat in IDLE: dropped (never enters the pipe), err_no_sop=1 for one cycle.
- Counter for lane j of a beat: ctr_j = (key_q + idx + j) mod 256.
  - On a sop beat, the new key and idx=0 are used for that same beat.
  - After each accepted in-message beat: idx += LANES, or popcount(in_keep) when CTR_STEP_KEEP=1.
  - idx is 8 bits and wraps silently at 256.
- Pipeline:
  - S1 registers data, keep, framing and ctr_j.
  - S2 registers out_data_j = keep_j ? data_j ^ SBOX[ctr_j] : 0x00.
  - Latency from accept to out_valid is exactly 2 cycles when not stalled; throughput is 1 beat/cycle.
- Stall: a stage advances iff it is empty or its downstream advances.
  - in_ready = !s1_valid | s1_advance. This is combinational from out_ready; no skid buffer is needed.
  - Registered outputs hold stable while out_valid & !out_ready.
- Reset values:
  - in_ready=1 during reset deassertion; out_valid=0, out_data=0, out_keep=0, out_sop=0, out_last=0, err_no_sop=0.
  - State=IDLE, idx=0, key_q=0.
  - Reset mid-message discards all in-flight beats; no output is produced for them.
- in_keep=0 on an accepted beat: the beat still flows, with out_data=0. idx advances by LANES, or by 0 when CTR_STEP_KEEP=1.

Decomposition:
- hes_pkg holds:
  - the 256-entry constant SBOX table, row-major: SBOX[0x00]=0x52, SBOX[0x01]=0x09, SBOX[0x02]=0x6a, SBOX[0x03]=0xd5, SBOX[0xfe]=0x0c, SBOX[0xff]=0x7d;
  - typedef byte_t;
  - localparam CTR_W=8.
- One sub-module, hes_sbox_lane: a registered lookup plus XOR with keep masking, instantiated LANES times in S2.

Test Plan:
- LANES=4, key=0x00, one beat with sop=last=1, data=0x00000000, keep=4'hF -> after 2 cycles out_data=0xd56a0952, out_sop=out_last=1.
- key=0xFE, same zero beat -> counters fe,ff,00,01 -> out_data=0x09527d0c (wrap-around).
- Round trip: 3-beat message, key=0x5A; feed the outputs back in as a new message with the same key -> original data recovered exactly.
- Backpressure: stream 8 beats with out_ready=0 for cycles 3..7 -> in_ready falls once both stages are full; no beat is lost, duplicated or reordered; out_data is stable while stalled.
- keep=4'b0011, CTR_STEP_KEEP=1, 2-beat message -> lanes 2,3 output 0x00; beat 2 uses idx=2 (counters key+2..key+5).
- Beat without sop in IDLE -> nothing on the output, err_no_sop pulses 1 cycle.
- rst_n asserted while 2 beats are in flight -> out_valid=0 immediately; after release, the next sop message starts with idx=0.

Source files
------------

// File: rtl/hes_pkg.sv
// hes_pkg: shared byte type, counter width and SBOX table for the HES stream cipher
package hes_pkg;
  localparam int CTR_W = 8;
  typedef logic [CTR_W-1:0] byte_t;
  localparam byte_t SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
endpackage

// File: rtl/hes_sbox_lane.sv
// hes_sbox_lane: one registered keystream byte (SBOX[ctr] ^ data), zeroed when the lane is masked
// ports: clk/rst_n; en loads the register; keep, data, ctr in; q registered result
module hes_sbox_lane
  import hes_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  keep,
  input  byte_t data,
  input  byte_t ctr,
  output byte_t q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= keep ? data ^ SBOX[ctr] : '0;
endmodule

// File: rtl/hes_ctr_stream_pipe.sv
// hes_ctr_stream_pipe: LANES-byte-per-beat HES counter-mode cipher, 2-stage valid/ready pipeline
// ports: clk, rst_n (async, active-low); key sampled on sop; in_* beat (valid/ready/sop/last/keep/data);
// out_* beat (valid/ready/sop/last/keep/data); err_no_sop pulses when a beat without sop arrives in IDLE
module hes_ctr_stream_pipe
  import hes_pkg::*;
#(
  parameter int LANES         = 4,
  parameter bit CTR_STEP_KEEP = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  byte_t              key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sop,
  input  logic               in_last,
  input  logic [LANES-1:0]   in_keep,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sop,
  output logic               out_last,
  output logic [LANES-1:0]   out_keep,
  output logic [8*LANES-1:0] out_data,
  output logic               err_no_sop
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  byte_t key_q, idx, key_eff, idx_eff, kcnt, step;
  logic s1_valid, s1_sop, s1_last, s1_adv, s2_adv, acc, take, drop;
  logic [LANES-1:0] s1_keep;
  logic [8*LANES-1:0] s1_data;
  byte_t s1_ctr [LANES];
  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign acc      = in_valid & in_ready;
  assign take     = acc & (in_sop | state == ACTIVE);
  assign drop     = acc & !in_sop & state == IDLE;
  // a sop beat uses its own key and idx=0 immediately, which also covers restart while ACTIVE
  assign key_eff  = in_sop ? key : key_q;
  assign idx_eff  = in_sop ? '0 : idx;
  assign step     = CTR_STEP_KEEP ? kcnt : byte_t'(LANES);
  always_comb begin
    kcnt = '0;
    for (int i = 0; i < LANES; i++) kcnt = kcnt + byte_t'(in_keep[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      key_q      <= '0;
      idx        <= '0;
      err_no_sop <= 1'b0;
    end else begin
      err_no_sop <= drop;
      if (take) begin
        key_q <= key_eff;
        idx   <= idx_eff + step;
        state <= in_last ? IDLE : ACTIVE;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sop   <= 1'b0;
      s1_last  <= 1'b0;
      s1_keep  <= '0;
      s1_data  <= '0;
      for (int i = 0; i < LANES; i++) s1_ctr[i] <= '0;
    end else if (s1_adv) begin
      s1_valid <= take;
      if (take) begin
        s1_sop  <= in_sop;
        s1_last <= in_last;
        s1_keep <= in_keep;
        s1_data <= in_data;
        for (int i = 0; i < LANES; i++) s1_ctr[i] <= key_eff + idx_eff + byte_t'(i);
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_last  <= 1'b0;
      out_keep  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sop  <= s1_sop;
        out_last <= s1_last;
        out_keep <= s1_keep;
      end
    end
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    hes_sbox_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (s2_adv & s1_valid),
      .keep (s1_keep[j]),
      .data (s1_data[8*j+:8]),
      .ctr  (s1_ctr[j]),
      .q    (out_data[8*j+:8])
    );
  end
endmodule

// File: tb/tb_hes_ctr_stream_pipe.sv
// tb_hes_ctr_stream_pipe: randomized and directed scoreboard bench for both counter-step modes
module tb_hes_ctr_stream_pipe;
  import hes_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  byte_t key;
  logic in_valid, in_sop, in_last, out_ready;
  logic [3:0] in_keep;
  logic [31:0] in_data;
  logic in_ready0, out_valid0, out_sop0, out_last0, err0;
  logic in_ready1, out_valid1, out_sop1, out_last1, err1;
  logic [3:0] out_keep0, out_keep1;
  logic [31:0] out_data0, out_data1;
  hes_ctr_stream_pipe #(.LANES(4), .CTR_STEP_KEEP(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .key(key), .in_valid(in_valid), .in_ready(in_ready0),
    .in_sop(in_sop), .in_last(in_last), .in_keep(in_keep), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sop(out_sop0), .out_last(out_last0),
    .out_keep(out_keep0), .out_data(out_data0), .err_no_sop(err0)
  );
  hes_ctr_stream_pipe #(.LANES(4), .CTR_STEP_KEEP(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .key(key), .in_valid(in_valid), .in_ready(in_ready1),
    .in_sop(in_sop), .in_last(in_last), .in_keep(in_keep), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sop(out_sop1), .out_last(out_last1),
    .out_keep(out_keep1), .out_data(out_data1), .err_no_sop(err1)
  );
  typedef struct {
    logic [31:0] d0, d1;
    logic [3:0] keep;
    logic sop, last;
  } exp_t;
  exp_t q[$];
  logic [31:0] got0[$], got1[$];
  int checks = 0, errors = 0;
  logic act = 1'b0, drop_prev = 1'b0, stall_prev = 1'b0, last_acc = 1'b0, saw_nr = 1'b0;
  byte_t mkey, mi0, mi1;
  logic [31:0] hold0, w, ct[3], orig[3], bp[8], kd[2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] enc(byte_t k, byte_t i, logic [31:0] d, logic [3:0] kp);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j+:8] = kp[j] ? d[8*j+:8] ^ SBOX[8'(k + i + 8'(j))] : 8'h00;
    return r;
  endfunction
  task automatic tick();
    exp_t e;
    #1;
    chk("err_no_sop0", 32'(err0), 32'(drop_prev));
    chk("err_no_sop1", 32'(err1), 32'(drop_prev));
    if (stall_prev) chk("stall_hold", out_data0, hold0);
    if (out_valid0 && out_ready) begin
      got0.push_back(out_data0);
      got1.push_back(out_data1);
      if (q.size() == 0) chk("spurious_out", 32'(1), 32'(0));
      else begin
        e = q.pop_front();
        chk("data_step_lanes", out_data0, e.d0);
        chk("data_step_keep", out_data1, e.d1);
        chk("keep", 32'(out_keep0), 32'(e.keep));
        chk("framing", 32'({out_sop0, out_last0}), 32'({e.sop, e.last}));
      end
    end
    stall_prev = out_valid0 && !out_ready;
    hold0 = out_data0;
    if (!in_ready0) saw_nr = 1'b1;
    last_acc = in_valid && in_ready0 && rst_n;
    drop_prev = 1'b0;
    if (last_acc) begin
      if (in_sop) begin
        act = 1'b1; mkey = key; mi0 = 8'h00; mi1 = 8'h00;
      end
      if (!act) drop_prev = 1'b1;
      else begin
        e.d0 = enc(mkey, mi0, in_data, in_keep);
        e.d1 = enc(mkey, mi1, in_data, in_keep);
        e.keep = in_keep; e.sop = in_sop; e.last = in_last;
        q.push_back(e);
        mi0 = mi0 + 8'd4;
        mi1 = mi1 + 8'($countones(in_keep));
        if (in_last) act = 1'b0;
      end
    end
    @(negedge clk);
  endtask
  task automatic send(input byte_t k, input logic s, input logic l, input logic [3:0] kp, input logic [31:0] d);
    key = k; in_sop = s; in_last = l; in_keep = kp; in_data = d; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) chk("send_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    key = '0; in_valid = 0; in_sop = 0; in_last = 0; in_keep = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready0), 32'(1));
    chk("rst_out_valid", 32'(out_valid0), 32'(0));
    chk("rst_out_data", out_data0, 32'(0));
    chk("rst_framing", 32'({out_sop0, out_last0, out_keep0}), 32'(0));
    chk("rst_err", 32'(err0), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    got0.delete();
    send(8'h00, 1, 1, 4'hF, 32'h0);
    chk("lat_s1", 32'(out_valid0), 32'(0));
    idle(1);
    chk("lat_s2", 32'(out_valid0), 32'(1));
    chk("vec_framing", 32'({out_sop0, out_last0}), 32'(2'b11));
    idle(2);
    w = got0.size() > 0 ? got0[0] : 32'hx;
    chk("vec_key00", w, 32'hd56a0952);
    got0.delete();
    send(8'hFE, 1, 1, 4'hF, 32'h0);
    idle(3);
    w = got0.size() > 0 ? got0[0] : 32'hx;
    chk("vec_keyfe_wrap", w, 32'h09527d0c);
    for (int i = 0; i < 3; i++) orig[i] = $urandom;
    got0.delete();
    for (int i = 0; i < 3; i++) send(8'h5A, i == 0, i == 2, 4'hF, orig[i]);
    idle(4);
    chk("rt_count", got0.size(), 32'(3));
    for (int i = 0; i < 3; i++) ct[i] = got0.size() > i ? got0[i] : 32'hx;
    got0.delete();
    for (int i = 0; i < 3; i++) send(8'h5A, i == 0, i == 2, 4'hF, ct[i]);
    idle(4);
    for (int i = 0; i < 3; i++) begin
      w = got0.size() > i ? got0[i] : 32'hx;
      chk("round_trip", w, orig[i]);
    end
    for (int i = 0; i < 8; i++) bp[i] = $urandom;
    got0.delete();
    saw_nr = 1'b0;
    begin
      int sent = 0, c = 0;
      while (sent < 8 && c < 60) begin
        out_ready = !(c >= 3 && c <= 7);
        key = 8'hC3; in_valid = 1'b1; in_sop = sent == 0; in_last = sent == 7;
        in_keep = 4'hF; in_data = bp[sent];
        tick();
        if (last_acc) sent++;
        c++;
      end
      chk("bp_all_sent", sent, 32'(8));
    end
    out_ready = 1'b1;
    idle(4);
    chk("bp_ready_fell", 32'(saw_nr), 32'(1));
    chk("bp_count", got0.size(), 32'(8));
    for (int i = 0; i < 8; i++) begin
      w = got0.size() > i ? got0[i] : 32'hx;
      chk("bp_order", w, enc(8'hC3, 8'(4 * i), bp[i], 4'hF));
    end
    kd[0] = $urandom; kd[1] = $urandom;
    got1.delete();
    send(8'h33, 1, 0, 4'b0011, kd[0]);
    send(8'h33, 0, 1, 4'b0011, kd[1]);
    idle(4);
    w = got1.size() > 1 ? got1[1] : 32'hx;
    chk("keep_step_lanes", {16'h0, w[15:0]}, {16'h0, kd[1][15:8] ^ SBOX[8'h36], kd[1][7:0] ^ SBOX[8'h35]});
    chk("keep_masked_zero", {16'h0, w[31:16]}, 32'h0);
    send(8'h77, 0, 0, 4'hF, $urandom);
    chk("err_pulse_hi", 32'(err0), 32'(1));
    idle(1);
    chk("err_pulse_lo", 32'(err0), 32'(0));
    idle(2);
    chk("drop_no_out", q.size(), 32'(0));
    send(8'h11, 1, 0, 4'hF, $urandom);
    send(8'h11, 0, 0, 4'hF, $urandom);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid0), 32'(0));
    chk("rst_mid_data", out_data0, 32'(0));
    q.delete(); act = 1'b0; drop_prev = 1'b0; stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    got0.delete();
    w = $urandom;
    send(8'h11, 1, 1, 4'hF, w);
    idle(3);
    chk("post_rst_count", got0.size(), 32'(1));
    chk("post_rst_idx0", got0.size() > 0 ? got0[0] : 32'hx, enc(8'h11, 8'h00, w, 4'hF));
    for (int n = 0; n < 400; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_sop = $urandom_range(0, 4) == 0;
      in_last = $urandom_range(0, 3) == 0;
      in_keep = 4'($urandom);
      in_data = $urandom;
      key = 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    out_ready = 1'b1;
    idle(6);
    chk("drain", q.size(), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
